// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Reset release sequencer that sits behind the reset synchroniser. It keeps
// N_STAGE downstream active-low resets asserted for HOLD_CYC cycles. It then
// releases them one at a time in index order. After each release it waits for
// that stage to report ready, then pauses GAP_CYC cycles before releasing the
// next one. A stage that never reports ready within TMO_CYC cycles is an
// error. So is any stage losing ready once the whole chain is up. An error
// pulls every reset back down. Software can re-run the whole sequence from
// DONE or ERR with soft_req.
//
// Ports
//   clk        in   1         single clock, rising edge
//   rst        in   1         synchronous active-high reset
//   soft_req   in   1         level re-sequence request, held until soft_ack
//   stage_rdy  in   N_STAGE   per-stage ready, synchronous to clk
//   rstn_out   out  N_STAGE   registered active-low resets to downstream
//   soft_ack   out  1         one-cycle pulse when soft_req is accepted
//   done       out  1         all stages released and ready
//   err        out  1         timeout or ready loss detected
//   err_stage  out  IDX_W     index of the failing stage
// ----------------------------------------------------------------------------
module rst_seq_ctrl #(
    parameter int N_STAGE  = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8,
    parameter int TMO_CYC  = 1024,
    parameter int CNT_W    = 12,
    localparam int IDX_W   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_req,
    input  logic [N_STAGE-1:0] stage_rdy,
    output logic [N_STAGE-1:0] rstn_out,
    output logic               soft_ack,
    output logic               done,
    output logic               err,
    output logic [IDX_W-1:0]   err_stage
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_STAGE-1:0] rstn_q, rstn_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_stage_q, err_stage_d;
    logic               ack_q, ack_d;
    logic [IDX_W-1:0]   lost_idx;
    logic               any_lost;

    // All state and every output lives in one register bank. That way no
    // input can reach an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rstn_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rstn_q      <= rstn_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            ack_q       <= ack_d;
        end
    end

    // Lowest-numbered stage that has dropped ready. The scan runs from the top
    // down, so the last hit is the smallest index.
    always_comb begin
        lost_idx = '0;
        any_lost = 1'b0;
        for (int k = N_STAGE - 1; k >= 0; k--) begin
            if (!stage_rdy[k]) begin
                lost_idx = IDX_W'(k);
                any_lost = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for the sequencer.
    // A software request is only honoured in DONE or ERR. In DONE it takes
    // priority over a simultaneous ready loss. In WAIT, a ready seen on the
    // timeout cycle still counts as success.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rstn_d      = rstn_q;
        done_d      = done_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        ack_d       = 1'b0;

        unique case (state_q)
            S_HOLD: begin
                rstn_d = '0;
                if (cnt_q == HOLD_LAST) begin
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rstn_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (stage_rdy[idx_q]) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = S_ERR;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    err_stage_d = idx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    for (int k = 0; k < N_STAGE; k++) begin
                        if (k == int'(idx_q) + 1) begin
                            rstn_d[k] = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                if (soft_req) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    rstn_d      = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_stage_d = '0;
                    ack_d       = 1'b1;
                end else if (any_lost) begin
                    state_d     = S_ERR;
                    done_d      = 1'b0;
                    err_d       = 1'b1;
                    err_stage_d = lost_idx;
                end
            end

            S_ERR: begin
                // Outputs drop one edge after the error is flagged.
                rstn_d = '0;
                if (soft_req) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_stage_d = '0;
                    ack_d       = 1'b1;
                end
            end

            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rstn_d  = '0;
            end
        endcase
    end

    assign rstn_out  = rstn_q;
    assign soft_ack  = ack_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_stage = err_stage_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Directed bench for rst_seq_ctrl with the default parameters (4 stages,
// hold 16, gap 8, timeout 1024). Edge numbers in the comments count rising
// edges after the event named there. Release timing follows the counter
// rules:
//   - stage 0 is released on edge 16 after reset or accept;
//   - each later stage is released 9 edges after the previous one
//     (1 WAIT edge plus 8 GAP edges);
//   - done rises one edge after the last release.
// Outputs are sampled 1 time unit after a rising edge, and inputs change at
// that same point.
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       soft_req;
    logic [3:0] stage_rdy;
    logic [3:0] rstn_out;
    logic       soft_ack;
    logic       done;
    logic       err;
    logic [1:0] err_stage;

    int checks;
    int failures;

    rst_seq_ctrl #(
        .N_STAGE  (4),
        .HOLD_CYC (16),
        .GAP_CYC  (8),
        .TMO_CYC  (1024),
        .CNT_W    (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .soft_req  (soft_req),
        .stage_rdy (stage_rdy),
        .rstn_out  (rstn_out),
        .soft_ack  (soft_ack),
        .done      (done),
        .err       (err),
        .err_stage (err_stage)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic sreq, input logic [3:0] rdy);
        rst       = r;
        soft_req  = sreq;
        stage_rdy = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus(1'b1, 1'b0, 4'b1111);
        tick(2);

        // Reset values.
        checkOutput("rst_rstn",      32'(rstn_out),  32'h0);
        checkOutput("rst_done",      32'(done),      32'h0);
        checkOutput("rst_err",       32'(err),       32'h0);
        checkOutput("rst_err_stage", 32'(err_stage), 32'h0);
        checkOutput("rst_ack",       32'(soft_ack),  32'h0);

        // Normal sequence with every stage ready.
        applyStimulus(1'b0, 1'b0, 4'b1111);
        tick(15);                                              // edge 15
        checkOutput("hold_last",   32'(rstn_out), 32'h0);
        tick(1);                                               // edge 16
        checkOutput("rel0",        32'(rstn_out), 32'h1);
        checkOutput("rel0_done",   32'(done),     32'h0);
        tick(8);                                               // edge 24
        checkOutput("gap0_last",   32'(rstn_out), 32'h1);
        tick(1);                                               // edge 25
        checkOutput("rel1",        32'(rstn_out), 32'h3);
        tick(9);                                               // edge 34
        checkOutput("rel2",        32'(rstn_out), 32'h7);
        tick(9);                                               // edge 43
        checkOutput("rel3",        32'(rstn_out), 32'hF);
        checkOutput("rel3_done",   32'(done),     32'h0);
        tick(1);                                               // edge 44
        checkOutput("done",        32'(done),     32'h1);
        checkOutput("done_err",    32'(err),      32'h0);

        // Ready loss in DONE on stages 1 and 3; the lowest index is reported.
        applyStimulus(1'b0, 1'b0, 4'b0101);
        tick(1);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("loss_err",       32'(err),       32'h1);
        checkOutput("loss_err_stage", 32'(err_stage), 32'h1);
        checkOutput("loss_done",      32'(done),      32'h0);
        checkOutput("loss_rstn_hold", 32'(rstn_out),  32'hF);
        tick(1);
        checkOutput("loss_rstn_low",  32'(rstn_out),  32'h0);
        checkOutput("loss_err_stay",  32'(err),       32'h1);

        // Software re-sequence from ERR.
        applyStimulus(1'b0, 1'b1, 4'b1111);
        tick(1);                                               // accept edge A
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("sreq_ack",    32'(soft_ack), 32'h1);
        checkOutput("sreq_err",    32'(err),      32'h0);
        checkOutput("sreq_rstn",   32'(rstn_out), 32'h0);
        tick(1);                                               // A+1
        checkOutput("sreq_ack_pulse", 32'(soft_ack), 32'h0);
        tick(14);                                              // A+15
        checkOutput("sreq_hold",   32'(rstn_out), 32'h0);
        tick(1);                                               // A+16
        checkOutput("sreq_rel0",   32'(rstn_out), 32'h1);
        tick(27);                                              // A+43
        checkOutput("sreq_rel3",   32'(rstn_out), 32'hF);
        tick(1);                                               // A+44
        checkOutput("sreq_done",   32'(done),     32'h1);

        // Software re-sequence from DONE, then a request raised during the
        // stage 1 gap, which must wait for the next DONE.
        applyStimulus(1'b0, 1'b1, 4'b1111);
        tick(1);                                               // accept edge B
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("dreq_ack",    32'(soft_ack), 32'h1);
        checkOutput("dreq_done",   32'(done),     32'h0);
        tick(27);                                              // B+27, in GAP
        checkOutput("gap1_rstn",   32'(rstn_out), 32'h3);
        applyStimulus(1'b0, 1'b1, 4'b1111);
        for (int i = 0; i < 16; i++) begin                     // B+28..B+43
            tick(1);
            checkOutput("early_req_no_ack", 32'(soft_ack), 32'h0);
        end
        checkOutput("early_req_rel3", 32'(rstn_out), 32'hF);
        tick(1);                                               // B+44
        checkOutput("early_req_done",   32'(done),     32'h1);
        checkOutput("early_req_ack0",   32'(soft_ack), 32'h0);
        tick(1);                                               // B+45 = C
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("early_req_ack",    32'(soft_ack), 32'h1);
        checkOutput("early_req_ddone",  32'(done),     32'h0);
        checkOutput("early_req_rstn",   32'(rstn_out), 32'h0);

        // Synchronous reset while two stages are released.
        tick(25);                                              // C+25
        checkOutput("mid_rstn",    32'(rstn_out), 32'h3);
        applyStimulus(1'b1, 1'b0, 4'b1111);
        tick(1);                                               // edge R
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("mid_rst_rstn", 32'(rstn_out), 32'h0);
        checkOutput("mid_rst_done", 32'(done),     32'h0);
        tick(15);                                              // R+15
        checkOutput("mid_rst_hold", 32'(rstn_out), 32'h0);
        tick(1);                                               // R+16
        checkOutput("mid_rst_rel0", 32'(rstn_out), 32'h1);

        // Stage 2 never ready: timeout after 1024 WAIT cycles.
        applyStimulus(1'b0, 1'b0, 4'b1011);
        tick(18);                                              // R+34
        checkOutput("tmo_rel2",    32'(rstn_out), 32'h7);
        tick(1023);                                            // R+1057
        checkOutput("tmo_before",  32'(err),      32'h0);
        checkOutput("tmo_before_rstn", 32'(rstn_out), 32'h7);
        tick(1);                                               // R+1058
        checkOutput("tmo_err",       32'(err),       32'h1);
        checkOutput("tmo_err_stage", 32'(err_stage), 32'h2);
        checkOutput("tmo_done",      32'(done),      32'h0);
        tick(1);
        checkOutput("tmo_rstn_low",  32'(rstn_out),  32'h0);

        // Ready arriving on the timeout cycle itself wins over the timeout.
        applyStimulus(1'b0, 1'b1, 4'b1011);
        tick(1);                                               // accept edge S
        applyStimulus(1'b0, 1'b0, 4'b1011);
        checkOutput("edge_ack",    32'(soft_ack), 32'h1);
        tick(34);                                              // S+34
        checkOutput("edge_rel2",   32'(rstn_out), 32'h7);
        tick(1023);                                            // S+1057
        applyStimulus(1'b0, 1'b0, 4'b1111);
        tick(1);                                               // S+1058
        checkOutput("edge_no_err", 32'(err),      32'h0);
        checkOutput("edge_rstn",   32'(rstn_out), 32'h7);
        tick(8);                                               // S+1066
        checkOutput("edge_rel3",   32'(rstn_out), 32'hF);
        tick(1);                                               // S+1067
        checkOutput("edge_done",   32'(done),     32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
